// File: rtl/wb_in_loader_if.sv
// Input beat stream of the loader: valid/ready handshake with a 32-bit word and a 2-bit type.
interface wb_in_loader_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic [1:0]  s_type;

   modport master (output s_valid, output s_data, output s_type, input s_ready);
   modport slave  (input s_valid, input s_data, input s_type, output s_ready);
endinterface

// File: rtl/wb_in_loader.sv
// Loads plaintext, master key and MDS table packets from a beat stream into datapath registers.
// Optional WB_IN_BYTE_SWAP_EN byte-reverses every accepted word before use.
module wb_in_loader (
   input  logic           clk,
   input  logic           rst_n,
   wb_in_loader_if.slave  bus,
   input  logic           op_busy,
   output logic [127:0]   P,
   output logic [127:0]   MK,
   output logic           p_vld,
   output logic           mk_vld,
   output logic [31:0]    ram_MDS_i,
   output logic [4:0]     MDS_addr,
   output logic           mds_wen,
   output logic           mds_en,
   output logic           mds_done,
   output logic           go,
   output logic           err
);

   typedef enum logic [2:0] {StIdle, StLdP, StLdMk, StLdMds, StDrop} state_e;

   state_e        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [127:0]  p_q, p_d, mk_q, mk_d;
   logic          p_vld_q, p_vld_d, mk_vld_q, mk_vld_d;
   logic [31:0]   mds_data_q, mds_data_d;
   logic [4:0]    mds_addr_q, mds_addr_d;
   logic          mds_we_q, mds_we_d, mds_done_q, mds_done_d;
   logic          go_q, go_d, err_q, err_d;
   logic          accept;
   logic [31:0]   word;

`ifdef WB_IN_BYTE_SWAP_EN
   assign word = {bus.s_data[7:0], bus.s_data[15:8], bus.s_data[23:16], bus.s_data[31:24]};
`else
   assign word = bus.s_data;
`endif

   // Gated by rst_n so the stream sees no ready while reset is held.
   assign bus.s_ready = rst_n & ~op_busy;
   assign accept      = bus.s_valid & bus.s_ready;

   // Beat k lands in the k-th word from the top (first word is the MSW).
   function automatic logic [127:0] put_word(input logic [127:0] cur, input logic [1:0] k,
                                             input logic [31:0] w);
      logic [127:0] r;
      r = cur;
      unique case (k)
         2'd0: r[127:96] = w;
         2'd1: r[95:64]  = w;
         2'd2: r[63:32]  = w;
         2'd3: r[31:0]   = w;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      p_d        = p_q;
      mk_d       = mk_q;
      p_vld_d    = p_vld_q;
      mk_vld_d   = mk_vld_q;
      mds_data_d = mds_data_q;
      mds_addr_d = mds_addr_q;
      mds_we_d   = 1'b0;
      mds_done_d = mds_done_q;
      go_d       = 1'b0;
      err_d      = 1'b0;
      if (mds_we_q && (mds_addr_q == 5'd31)) mds_done_d = 1'b1;
      if (accept) begin
         unique case (state_q)
            StIdle: begin
               cnt_d = 5'd1;
               unique case (bus.s_type)
                  2'b00: begin
                     p_d     = put_word(p_q, 2'd0, word);
                     p_vld_d = 1'b0;
                     state_d = StLdP;
                  end
                  2'b01: begin
                     mk_d     = put_word(mk_q, 2'd0, word);
                     mk_vld_d = 1'b0;
                     state_d  = StLdMk;
                  end
                  2'b10: begin
                     mds_we_d   = 1'b1;
                     mds_addr_d = 5'd0;
                     mds_data_d = word;
                     mds_done_d = 1'b0;
                     state_d    = StLdMds;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = StDrop;
                  end
               endcase
            end
            StLdP: begin
               p_d = put_word(p_q, cnt_q[1:0], word);
               if (cnt_q == 5'd3) begin
                  p_vld_d = 1'b1;
                  go_d    = mk_vld_q;
                  cnt_d   = 5'd0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            StLdMk: begin
               mk_d = put_word(mk_q, cnt_q[1:0], word);
               if (cnt_q == 5'd3) begin
                  mk_vld_d = 1'b1;
                  cnt_d    = 5'd0;
                  state_d  = StIdle;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            StLdMds: begin
               mds_we_d   = 1'b1;
               mds_addr_d = cnt_q;
               mds_data_d = word;
               cnt_d      = cnt_q + 5'd1;  // wraps 31 -> 0 on the last beat
               if (cnt_q == 5'd31) state_d = StIdle;
            end
            StDrop: begin
               if (cnt_q == 5'd3) begin
                  cnt_d   = 5'd0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= 5'd0;
         p_q        <= '0;
         mk_q       <= '0;
         p_vld_q    <= 1'b0;
         mk_vld_q   <= 1'b0;
         mds_data_q <= '0;
         mds_addr_q <= '0;
         mds_we_q   <= 1'b0;
         mds_done_q <= 1'b0;
         go_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         p_q        <= p_d;
         mk_q       <= mk_d;
         p_vld_q    <= p_vld_d;
         mk_vld_q   <= mk_vld_d;
         mds_data_q <= mds_data_d;
         mds_addr_q <= mds_addr_d;
         mds_we_q   <= mds_we_d;
         mds_done_q <= mds_done_d;
         go_q       <= go_d;
         err_q      <= err_d;
      end
   end

   assign P         = p_q;
   assign MK        = mk_q;
   assign p_vld     = p_vld_q;
   assign mk_vld    = mk_vld_q;
   assign ram_MDS_i = mds_data_q;
   assign MDS_addr  = mds_addr_q;
   assign mds_wen   = mds_we_q;
   assign mds_en    = mds_we_q;
   assign mds_done  = mds_done_q;
   assign go        = go_q;
   assign err       = err_q;

endmodule

// File: tb/tb_wb_in_loader.sv
// Randomized self-checking bench for wb_in_loader against a packet-level reference model.
module tb_wb_in_loader;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          op_busy = 1'b0;
   logic [127:0]  P, MK;
   logic          p_vld, mk_vld;
   logic [31:0]   ram_MDS_i;
   logic [4:0]    MDS_addr;
   logic          mds_wen, mds_en, mds_done, go, err;

   wb_in_loader_if bus ();

   wb_in_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .op_busy   (op_busy),
      .P         (P),
      .MK        (MK),
      .p_vld     (p_vld),
      .mk_vld    (mk_vld),
      .ram_MDS_i (ram_MDS_i),
      .MDS_addr  (MDS_addr),
      .mds_wen   (mds_wen),
      .mds_en    (mds_en),
      .mds_done  (mds_done),
      .go        (go),
      .err       (err)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   int            go_seen = 0, err_seen = 0, exp_go = 0, exp_err = 0;
   logic [127:0]  ref_p = '0, ref_mk = '0;
   logic          ref_p_vld = 1'b0, ref_mk_vld = 1'b0, ref_done = 1'b0;
   logic [36:0]   got_q[$];
   logic [36:0]   exp_q[$];
   logic [31:0]   pkt[32];
   bit            rand_stall = 1'b0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] tw(input logic [31:0] w);
`ifdef WB_IN_BYTE_SWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // Observe pulses and MDS writes away from the active edge.
   always @(negedge clk) begin
      if (go) go_seen++;
      if (err) err_seen++;
      if (mds_en || mds_wen) begin
         check_eq("mds_wen_eq_en", {127'd0, mds_wen}, {127'd0, mds_en});
         if (mds_en) got_q.push_back({MDS_addr, ram_MDS_i});
      end
   end

   task automatic check_reset_vals();
      check_eq("rst_P", P, '0);
      check_eq("rst_MK", MK, '0);
      check_eq("rst_p_vld", p_vld, 0);
      check_eq("rst_mk_vld", mk_vld, 0);
      check_eq("rst_mds_en", mds_en, 0);
      check_eq("rst_mds_wen", mds_wen, 0);
      check_eq("rst_MDS_addr", MDS_addr, 0);
      check_eq("rst_ram_MDS_i", ram_MDS_i, 0);
      check_eq("rst_mds_done", mds_done, 0);
      check_eq("rst_go", go, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_s_ready", bus.s_ready, 0);
   endtask

   task automatic check_state();
      check_eq("P", P, ref_p);
      check_eq("MK", MK, ref_mk);
      check_eq("p_vld", p_vld, ref_p_vld);
      check_eq("mk_vld", mk_vld, ref_mk_vld);
      check_eq("mds_done", mds_done, ref_done);
      check_eq("go_count", go_seen, exp_go);
      check_eq("err_count", err_seen, exp_err);
      check_eq("mds_writes", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check_eq("mds_write", got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   // Starts and ends at 1 time unit after a rising edge; the beat is accepted on exactly one edge.
   task automatic send_beat(input logic [31:0] d, input logic [1:0] t);
      int gaps;
      gaps = rand_stall ? $urandom_range(0, 2) : 0;
      for (int i = 0; i < gaps; i++) begin
         op_busy     = 1'($urandom_range(0, 1));
         bus.s_valid = op_busy ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.s_data  = $urandom;
         bus.s_type  = 2'($urandom);
         #1;
         if (op_busy) check_eq("s_ready_busy", bus.s_ready, 0);
         @(posedge clk);
         #1;
      end
      op_busy     = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_type  = t;
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_data  = $urandom;
      bus.s_type  = 2'($urandom);
   endtask

   task automatic send_packet(input logic [1:0] t, input bit busy_mid);
      int nb;
      nb = (t == 2'b10) ? 32 : 4;
      for (int k = 0; k < nb; k++) begin
         send_beat(pkt[k], (k == 0) ? t : 2'($urandom));
         if (k == 0) begin
            case (t)
               2'b00: check_eq("p_vld_clear", p_vld, 0);
               2'b01: check_eq("mk_vld_clear", mk_vld, 0);
               2'b10: check_eq("mds_done_clear", mds_done, 0);
               default: check_eq("err_pulse", err, 1);
            endcase
         end
         if (busy_mid && k == 1) begin
            op_busy     = 1'b1;
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
            repeat (5) begin
               #1;
               check_eq("s_ready_busy_mid", bus.s_ready, 0);
               @(posedge clk);
               #1;
            end
            check_eq("p_partial", P, {tw(pkt[0]), tw(pkt[1]), ref_p[63:0]});
            check_eq("p_vld_partial", p_vld, 0);
            op_busy     = 1'b0;
            bus.s_valid = 1'b0;
         end
      end
      if (t == 2'b00) check_eq("go_pulse", go, ref_mk_vld);
      case (t)
         2'b00: begin
            ref_p     = {tw(pkt[0]), tw(pkt[1]), tw(pkt[2]), tw(pkt[3])};
            ref_p_vld = 1'b1;
            if (ref_mk_vld) exp_go++;
         end
         2'b01: begin
            ref_mk     = {tw(pkt[0]), tw(pkt[1]), tw(pkt[2]), tw(pkt[3])};
            ref_mk_vld = 1'b1;
         end
         2'b10: begin
            for (int k = 0; k < 32; k++) exp_q.push_back({5'(k), tw(pkt[k])});
            ref_done = 1'b1;
         end
         default: exp_err++;
      endcase
      repeat (2) @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic fill_random();
      for (int k = 0; k < 32; k++) pkt[k] = $urandom;
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_type  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("s_ready_idle", bus.s_ready, 1);

      // Plaintext then key with no prior key: go must stay low throughout.
      fill_random();
      send_packet(2'b00, 1'b0);
      fill_random();
      send_packet(2'b01, 1'b0);
      check_eq("no_go_yet", go_seen, 0);

      // Key then plaintext.
      pkt[0] = 32'h00010203; pkt[1] = 32'h04050607; pkt[2] = 32'h08090A0B; pkt[3] = 32'h0C0D0E0F;
      send_packet(2'b01, 1'b0);
      for (int k = 0; k < 4; k++) pkt[k] = 32'hDEADBEEF;
      send_packet(2'b00, 1'b0);
`ifndef WB_IN_BYTE_SWAP_EN
      check_eq("mk_const", MK, 128'h000102030405060708090A0B0C0D0E0F);
      check_eq("p_const", P, {4{32'hDEADBEEF}});
`endif
      check_eq("go_once", go_seen, 1);

`ifdef WB_IN_BYTE_SWAP_EN
      fill_random();
      pkt[0] = 32'h11223344;
      send_packet(2'b00, 1'b0);
      check_eq("swap_word0", P[127:96], 32'h44332211);
`endif

      // MDS table k*0x01010101.
      for (int k = 0; k < 32; k++) pkt[k] = 32'(k) * 32'h01010101;
      send_packet(2'b10, 1'b0);

      // Busy stall between plaintext beats 1 and 2.
      fill_random();
      send_packet(2'b00, 1'b1);

      // Illegal type, then a normal plaintext.
      fill_random();
      send_packet(2'b11, 1'b0);
      fill_random();
      send_packet(2'b00, 1'b0);

      // Reset in the middle of a key packet.
      send_beat(32'hA5A5A5A5, 2'b01);
      send_beat(32'h5A5A5A5A, 2'b00);
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      ref_p = '0; ref_mk = '0; ref_p_vld = 1'b0; ref_mk_vld = 1'b0; ref_done = 1'b0;
      got_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fill_random();
      send_packet(2'b00, 1'b0);

      // Randomized traffic with stalls.
      rand_stall = 1'b1;
      repeat (40) begin
         fill_random();
         send_packet(2'($urandom), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/wb_in_loader.md
WB_IN_LOADER -- requirements
Module: wb_in_loader

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: s_valid  in  1  input beat valid; s_ready  out  1  input beat accepted when both high; s_data  in  32  payload word; s_type  in  2  packet type (00 plaintext, 01 master key, 10 MDS table, 11 illegal), sampled on the first beat only.
REQ-003 SHALL have ports: op_busy  in  1  datapath running; P  out  128  plaintext to datapath; MK  out  128  master key to datapath; p_vld  out  1  P complete; mk_vld  out  1  MK complete.
REQ-004 SHALL have ports: ram_MDS_i  out  32  MDS write data; MDS_addr  out  5  MDS bank address; mds_wen  out  1  write enable, feeds WEN[1]; mds_en  out  1  bank enable, feeds EN[1]; mds_done  out  1  all 32 MDS words written.
REQ-005 SHALL have ports: go  out  1  one-cycle start pulse; err  out  1  one-cycle illegal-type pulse.

Function
REQ-006 SHALL implement FSM states IDLE, LD_P, LD_MK, LD_MDS, DROP, driven by a 5-bit beat counter cnt.
REQ-007 SHALL drive s_ready = 1 in IDLE, LD_P, LD_MK, LD_MDS and DROP, except s_ready = 0 whenever op_busy = 1.
REQ-008 In IDLE, an accepted beat SHALL latch s_type, be processed as beat 0, set cnt = 1, and enter LD_P, LD_MK, LD_MDS or DROP for type 00, 01, 10 or 11 respectively.
REQ-009 Plaintext and key packets SHALL be 4 beats; beat k SHALL be written to bits [127-32k -: 32] of P or MK (first word is the MSW).
REQ-010 On acceptance of beat 3 of a P packet, p_vld SHALL be set and the FSM SHALL return to IDLE; the same holds for MK packets and mk_vld.
REQ-011 go SHALL pulse high exactly one cycle after the cycle in which the last P beat is accepted while mk_vld = 1 (or is set in the same cycle); go SHALL NOT fire on MK completion.
REQ-012 On acceptance of a new P packet's beat 0, p_vld SHALL clear; on a new MK packet's beat 0, mk_vld SHALL clear.
REQ-013 MDS packets SHALL be 32 beats; each accepted beat k SHALL produce, registered one cycle later, mds_en = 1, mds_wen = 1, MDS_addr = k, ram_MDS_i = word; otherwise mds_en = mds_wen = 0.
REQ-014 mds_done SHALL set in the cycle after the write of address 31 is issued, and SHALL clear on the next MDS packet's beat 0.
REQ-015 cnt SHALL wrap 31 -> 0 at the end of an MDS packet; the FSM SHALL then return to IDLE.
REQ-016 An illegal type (11) SHALL pulse err one cycle after beat 0; DROP SHALL discard 4 beats total, then return to IDLE, leaving all outputs unchanged.
REQ-017 A stall (s_valid = 0 or op_busy = 1) mid-packet SHALL hold state, cnt and all data; s_type on non-first beats SHALL be ignored.
REQ-018 The P and MK registers SHALL be updated only on accepted beats; P and MK SHALL remain stable while op_busy = 1.

Reset
REQ-019 While rst_n = 0: state = IDLE, cnt = 0, and P, MK, ram_MDS_i, MDS_addr, p_vld, mk_vld, mds_en, mds_wen, mds_done, go, err SHALL all be 0; s_ready SHALL be 0.
REQ-020 Reset asserted mid-packet SHALL abandon the packet; after release the first accepted beat SHALL be treated as beat 0.

Configuration
REQ-021 When WB_IN_BYTE_SWAP_EN is defined, every accepted s_data word SHALL be byte-reversed ({b0,b1,b2,b3}) before use in P, MK or ram_MDS_i; when it is undefined, words SHALL be used unmodified.

Verification
REQ-022 Key then plaintext: MK words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, then P words 0xDEADBEEF x4 -> MK = 0x000102...0F; P = 0xDEADBEEF repeated; go high for exactly 1 cycle after the 4th P beat.
REQ-023 Plaintext loaded with no key -> p_vld = 1, go never asserts; a subsequent key packet -> go still never asserts.
REQ-024 MDS packet with words 0..31 = k*0x01010101 -> 32 consecutive writes at addresses 0..31 with matching data; mds_done = 1 after address 31.
REQ-025 op_busy = 1 asserted between P beats 1 and 2 for 5 cycles -> s_ready = 0 throughout; P stays partial and completes correctly after op_busy drops.
REQ-026 s_type = 11 with 4 beats -> a single err pulse; P, MK and the MDS outputs unchanged; the next type-00 packet loads normally.
REQ-027 With WB_IN_BYTE_SWAP_EN defined, P word 0x11223344 in beat 0 -> P[127:96] = 0x44332211.
